if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC sequencing, req/ack
// instruction-memory handshake, a one-entry skid buffer for freezes, and branch redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] PC,
    output logic        if_valid
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] pc_plus_step;

    assign pc_plus_step = pc_q + STEP;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;

        if (branch_taken) begin
            // Redirect overrides freeze: the IF/ID slot is squashed regardless.
            pc_d         = branch_target;
            ifid_instr_d = NOP_WORD;
            ifid_pc_d    = 32'h0;
            ifid_valid_d = 1'b0;
            skid_instr_d = 32'h0;
            skid_pc_d    = 32'h0;
            case (state_q)
                ST_FETCH: begin
                    if (!imem_ack) begin
                        state_d      = ST_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                ST_HOLD:  state_d = ST_FETCH;
                default:  state_d = ST_DRAIN;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (freeze) begin
                        if (imem_ack) begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_plus_step;
                            pc_d         = pc_plus_step;
                            state_d      = ST_HOLD;
                        end
                    end else if (imem_ack) begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc_d    = pc_plus_step;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus_step;
                    end else begin
                        ifid_instr_d = NOP_WORD;
                        ifid_pc_d    = 32'h0;
                        ifid_valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        ifid_instr_d = skid_instr_q;
                        ifid_pc_d    = skid_pc_q;
                        ifid_valid_d = 1'b1;
                        skid_instr_d = 32'h0;
                        skid_pc_d    = 32'h0;
                        state_d      = ST_FETCH;
                    end
                end
                default: begin
                    // The response for the abandoned address is dropped on arrival.
                    if (imem_ack) begin
                        state_d = ST_FETCH;
                    end
                    if (!freeze) begin
                        ifid_instr_d = NOP_WORD;
                        ifid_pc_d    = 32'h0;
                        ifid_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_WORD;
            ifid_pc_q    <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // DRAIN keeps presenting the address whose response is still in flight.
    assign imem_req    = !reset && (state_q != ST_HOLD);
    assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign instruction = ifid_instr_q;
    assign PC          = ifid_pc_q;
    assign if_valid    = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, wait states, freeze/skid,
// branch drain, branch under freeze, PC wrap and reset while in HOLD.
module tb_if_fetch_stage;

    logic        clock;
    logic        reset;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic        if_valid;

    int n_checks;
    int n_fails;

    if_fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .PC            (PC),
        .if_valid      (if_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance one clock edge; inputs are then changed 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins,
                              input logic [31:0] pcv, input logic v);
        check({tag, ".instr"}, instruction, ins);
        check({tag, ".pc"}, PC, pcv);
        check({tag, ".valid"}, 32'(if_valid), 32'(v));
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] a);
        #1;
        check({tag, ".req"}, 32'(imem_req), 32'(r));
        if (r) check({tag, ".addr"}, imem_addr, a);
    endtask

    initial begin
        logic [31:0] a;
        n_checks      = 0;
        n_fails       = 0;
        reset         = 1'b1;
        freeze        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;

        // Reset
        #2;
        check("rst.req_low", 32'(imem_req), 32'h0);
        step();
        step();
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        check_req("rst_rel", 1'b1, 32'h0);

        // Zero-wait sequential fetch of 0x0..0xC
        for (int i = 0; i < 4; i++) begin
            a = 32'(i * 4);
            check_req($sformatf("seq%0d", i), 1'b1, a);
            imem_ack   = 1'b1;
            imem_rdata = a | 32'hA000_0000;
            step();
            check_ifid($sformatf("seq%0d", i), a | 32'hA000_0000, a + 32'd4, 1'b1);
        end

        // Freeze while 0x10 is acked: parked in the skid buffer
        freeze     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0010;
        check_req("frz.pre", 1'b1, 32'h10);
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_ifid($sformatf("frz%0d", i), 32'hA000_000C, 32'h10, 1'b1);
            check_req($sformatf("frz%0d", i), 1'b0, 32'h0);
            step();
        end
        check_ifid("frz2", 32'hA000_000C, 32'h10, 1'b1);
        freeze = 1'b0;
        step();
        check_ifid("unfrz", 32'hA000_0010, 32'h14, 1'b1);
        check_req("unfrz", 1'b1, 32'h14);

        // Two wait states at 0x14 and 0x18
        for (int k = 0; k < 2; k++) begin
            a = 32'h14 + 32'(k * 4);
            for (int w = 0; w < 2; w++) begin
                imem_ack = 1'b0;
                check_req($sformatf("ws%0d_%0d", k, w), 1'b1, a);
                step();
                check_ifid($sformatf("ws%0d_%0d", k, w), 32'h0, 32'h0, 1'b0);
            end
            imem_ack   = 1'b1;
            imem_rdata = a | 32'hA000_0000;
            check_req($sformatf("ws%0d_ack", k), 1'b1, a);
            step();
            check_ifid($sformatf("ws%0d_ack", k), a | 32'hA000_0000, a + 32'd4, 1'b1);
        end

        // One zero-wait fetch at 0x1C to reach 0x20
        imem_rdata = 32'hA000_001C;
        step();
        check_ifid("f1c", 32'hA000_001C, 32'h20, 1'b1);

        // Branch to 0x100 with 0x20 outstanding: drain the late response
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        check_ifid("br", 32'h0, 32'h0, 1'b0);
        check_req("drain0", 1'b1, 32'h20);
        step();
        check_ifid("drain1", 32'h0, 32'h0, 1'b0);
        check_req("drain1", 1'b1, 32'h20);
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0020;
        step();
        check_ifid("drain_ack", 32'h0, 32'h0, 1'b0);
        check_req("tgt", 1'b1, 32'h100);
        imem_rdata = 32'hA000_0100;
        step();
        check_ifid("tgt", 32'hA000_0100, 32'h104, 1'b1);

        // Branch together with freeze over a valid IF/ID; target near the top
        imem_ack      = 1'b0;
        freeze        = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        freeze       = 1'b0;
        check_ifid("brfrz", 32'h0, 32'h0, 1'b0);
        check_req("brfrz_drain", 1'b1, 32'h104);
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0104;
        step();
        check_ifid("brfrz_ack", 32'h0, 32'h0, 1'b0);
        check_req("wrap_pre", 1'b1, 32'hFFFF_FFFC);

        // PC wrap at 0xFFFF_FFFC
        imem_rdata = 32'hFFFF_FFFC;
        step();
        check_ifid("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);
        check_req("wrap_next", 1'b1, 32'h0);

        // Enter HOLD, then reset from there
        freeze     = 1'b1;
        imem_rdata = 32'hA000_0000;
        step();
        imem_ack = 1'b0;
        check_req("hold", 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        check("hold_rst.req", 32'(imem_req), 32'h0);
        step();
        reset  = 1'b0;
        freeze = 1'b0;
        check_ifid("hold_rst", 32'h0, 32'h0, 1'b0);
        check_req("hold_rst", 1'b1, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hA000_0000;
        step();
        check_ifid("post_rst", 32'hA000_0000, 32'h4, 1'b1);
        imem_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
